// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory read-modify-write controller: FSM states,
// access-size encoding and the small decode helpers used at request accept.
package mips_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } dmem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Half wins when both size strobes are high.
   function automatic size_e decode_size(input logic byte_sel, input logic half);
      if (half)
         return SZ_HALF;
      else if (byte_sel)
         return SZ_BYTE;
      else
         return SZ_WORD;
   endfunction

   function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
      case (size)
         SZ_HALF: return offset[0];
         SZ_WORD: return (offset != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/wdata_merge.sv
// Little-endian lane merge of right-aligned store data into an existing
// 32-bit SRAM word; purely combinational.
module wdata_merge
   import mips_mem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  size_e       size,
   input  logic [1:0]  offset,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SZ_BYTE: merged[{offset, 3'b000} +: 8] = data[7:0];
         SZ_HALF: begin
            if (offset[1])
               merged[31:16] = data[15:0];
            else
               merged[15:0] = data[15:0];
         end
         default: merged = data;
      endcase
   end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller turning CPU byte/half/word accesses into SRAM word
// cycles, with read-modify-write for sub-word stores. Define
// DMEM_ALIGN_CHECK_EN to reject misaligned half/word requests with resp_err.
module dmem_rmw_ctrl
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only while idle, and the
   // requester holds its fields stable while req_valid waits for req_ready.
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   // "byte" is a reserved word, hence byte_sel.
   input  logic              byte_sel,
   input  logic              half,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       write_data,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output dmem_state_e       fsm_state
);

   dmem_state_e state;
   logic        write_q;
   size_e       size_q;
   logic [1:0]  offset_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   size_e       req_size;
   logic        misaligned;
   logic        unused_addr_hi;

   assign req_size       = decode_size(byte_sel, half);
   assign fsm_state      = state;
   assign unused_addr_hi = ^address[ADDR_W-1:MEM_AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
   logic resp_err_q;
   assign misaligned = is_misaligned(req_size, address[1:0]);
   assign resp_err   = resp_err_q;
`else
   assign misaligned = 1'b0;
   assign resp_err   = 1'b0;
`endif

   // The merge source is the word captured at the end of WAIT, so mem_wdata
   // is a function of registers only and is stable throughout WR.
   wdata_merge u_merge (
      .old_word (word_q),
      .data     (wdata_q),
      .size     (size_q),
      .offset   (offset_q),
      .merged   (mem_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         write_q    <= 1'b0;
         size_q     <= SZ_BYTE;
         offset_q   <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
         resp_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  write_q   <= req_write;
                  size_q    <= req_size;
                  offset_q  <= address[1:0];
                  wdata_q   <= write_data;
                  mem_addr  <= address[MEM_AW+1:2];
                  if (misaligned) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
                     resp_err_q <= 1'b1;
`endif
                  end else if (req_write && (req_size == SZ_WORD)) begin
                     state  <= ST_WR;
                     mem_en <= 1'b1;
                     mem_we <= 1'b1;
                  end else begin
                     state  <= ST_RD;
                     mem_en <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               mem_en <= 1'b0;
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               // SRAM data for the RD cycle is valid here (one-cycle latency).
               word_q <= mem_rdata;
               if (write_q) begin
                  state  <= ST_WR;
                  mem_en <= 1'b1;
                  mem_we <= 1'b1;
               end else begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= mem_rdata;
               end
            end
            ST_WR: begin
               mem_en     <= 1'b0;
               mem_we     <= 1'b0;
               state      <= ST_RESP;
               resp_valid <= 1'b1;
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
               resp_err_q <= 1'b0;
`endif
               req_ready  <= 1'b1;
               state      <= ST_IDLE;
            end
            default: begin
               state      <= ST_IDLE;
               mem_en     <= 1'b0;
               mem_we     <= 1'b0;
               resp_valid <= 1'b0;
               req_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl with a one-cycle-latency SRAM model;
// honours DMEM_ALIGN_CHECK_EN for the misaligned-half scenario.
module tb_dmem_rmw_ctrl;
   import mips_mem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        byte_sel;
   logic        half;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   dmem_state_e fsm_state;

   int n_cmp = 0;
   int n_err = 0;

   // SRAM model plus a bench-side preload port
   logic [31:0] sram [0:1023];
   logic        pre_en;
   logic [9:0]  pre_idx;
   logic [31:0] pre_val;

   dmem_rmw_ctrl #(.ADDR_W(32), .MEM_AW(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .byte_sel   (byte_sel),
      .half       (half),
      .address    (address),
      .write_data (write_data),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .fsm_state  (fsm_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (pre_en)
         sram[pre_idx] <= pre_val;
      else if (mem_en) begin
         if (mem_we)
            sram[mem_addr] <= mem_wdata;
         else
            mem_rdata <= sram[mem_addr];
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   // Presents a request and returns 1 time unit after its accept edge.
   task automatic issue(input logic wr, input logic bs, input logic hf,
                        input logic [31:0] a, input logic [31:0] d);
      int guard = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; byte_sel = bs; half = hf;
      address = a; write_data = d;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   // Issues a request and returns at the negedge where resp_valid is seen.
   task automatic run_txn(input logic wr, input logic bs, input logic hf,
                          input logic [31:0] a, input logic [31:0] d, output int k);
      issue(wr, bs, hf, a, d);
      k = 0;
      @(negedge clk);
      while (!resp_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      if (!resp_valid) begin
         n_cmp++; n_err++;
         $display("FAIL resp_timeout: resp_valid=%0b required 1", resp_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; byte_sel = 1'b0; half = 1'b0;
      address = '0; write_data = '0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %0b required 0", req_ready); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %0b required 0", resp_valid); end
      n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err: got %0b required 0", resp_err); end
      n_cmp++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_resp_rdata: got %h required 0", resp_rdata); end
      n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_ctl: got en=%0b we=%0b required 0/0", mem_en, mem_we); end
      n_cmp++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h required 0/0", mem_addr, mem_wdata); end
      n_cmp++; if (fsm_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d required %0d", fsm_state, ST_IDLE); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %0b required 1", req_ready); end
   endtask

   task automatic test_load();
      preload(10'h040, 32'h11223344);
      issue(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
      @(negedge clk);
      n_cmp++; if (fsm_state !== ST_RD || mem_en !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL load_k0_rd: got st=%0d en=%0b we=%0b required %0d/1/0", fsm_state, mem_en, mem_we, ST_RD); end
      n_cmp++; if (mem_addr !== 10'h040) begin n_err++; $display("FAIL load_mem_addr: got %h required 040", mem_addr); end
      n_cmp++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL load_k0_hs: got rdy=%0b rv=%0b required 0/0", req_ready, resp_valid); end
      @(negedge clk);
      n_cmp++; if (fsm_state !== ST_WAIT || mem_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL load_k1_wait: got st=%0d en=%0b rv=%0b rdy=%0b required %0d/0/0/0", fsm_state, mem_en, resp_valid, req_ready, ST_WAIT); end
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL load_k2_resp: got rv=%0b rdy=%0b required 1/0", resp_valid, req_ready); end
      n_cmp++; if (resp_rdata !== 32'h11223344) begin n_err++; $display("FAIL load_rdata: got %h required 11223344", resp_rdata); end
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h11223344) begin n_err++; $display("FAIL load_k3_idle: got rv=%0b rdy=%0b rdata=%h required 0/1/11223344", resp_valid, req_ready, resp_rdata); end
   endtask

   task automatic test_byte_store();
      int pulses = 0;
      preload(10'h040, 32'h11223344);
      issue(1'b1, 1'b1, 1'b0, 32'h101, 32'hFFFFFFAA);
      @(negedge clk);
      pulses += int'(resp_valid);
      n_cmp++; if (fsm_state !== ST_RD || mem_en !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL byte_k0_rd: got st=%0d en=%0b we=%0b required %0d/1/0", fsm_state, mem_en, mem_we, ST_RD); end
      @(negedge clk);
      pulses += int'(resp_valid);
      n_cmp++; if (fsm_state !== ST_WAIT || mem_en !== 1'b0) begin n_err++; $display("FAIL byte_k1_wait: got st=%0d en=%0b required %0d/0", fsm_state, mem_en, ST_WAIT); end
      @(negedge clk);
      pulses += int'(resp_valid);
      n_cmp++; if (fsm_state !== ST_WR || mem_en !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL byte_k2_wr: got st=%0d en=%0b we=%0b required %0d/1/1", fsm_state, mem_en, mem_we, ST_WR); end
      n_cmp++; if (mem_wdata !== 32'h1122AA44 || mem_addr !== 10'h040) begin n_err++; $display("FAIL byte_wdata: got %h @%h required 1122aa44 @040", mem_wdata, mem_addr); end
      @(negedge clk);
      pulses += int'(resp_valid);
      n_cmp++; if (sram[10'h040] !== 32'h1122AA44) begin n_err++; $display("FAIL byte_mem: got %h required 1122aa44", sram[10'h040]); end
      n_cmp++; if (resp_rdata !== 32'h11223344) begin n_err++; $display("FAIL byte_rdata_hold: got %h required 11223344", resp_rdata); end
      @(negedge clk);
      pulses += int'(resp_valid);
      @(negedge clk);
      pulses += int'(resp_valid);
      n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL byte_resp_pulses: got %0d required 1", pulses); end
   endtask

   task automatic test_half_store();
      preload(10'h040, 32'h11223344);
      issue(1'b1, 1'b0, 1'b1, 32'h102, 32'h1234BEEF);
      repeat (3) @(negedge clk);
      n_cmp++; if (mem_we !== 1'b1 || mem_wdata !== 32'hBEEF3344) begin n_err++; $display("FAIL half_wdata: got we=%0b %h required 1 beef3344", mem_we, mem_wdata); end
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1 || sram[10'h040] !== 32'hBEEF3344) begin n_err++; $display("FAIL half_mem: got rv=%0b mem=%h required 1 beef3344", resp_valid, sram[10'h040]); end
      @(negedge clk);
   endtask

   task automatic test_word_store();
      preload(10'h041, 32'h0);
      issue(1'b1, 1'b0, 1'b0, 32'h104, 32'hDEADBEEF);
      @(negedge clk);
      n_cmp++; if (fsm_state !== ST_WR || mem_en !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL word_k0_wr: got st=%0d en=%0b we=%0b required %0d/1/1", fsm_state, mem_en, mem_we, ST_WR); end
      n_cmp++; if (mem_addr !== 10'h041 || mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_bus: got %h @%h required deadbeef @041", mem_wdata, mem_addr); end
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1 || mem_en !== 1'b0) begin n_err++; $display("FAIL word_k1_resp: got rv=%0b en=%0b required 1/0", resp_valid, mem_en); end
      n_cmp++; if (sram[10'h041] !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_mem: got %h required deadbeef", sram[10'h041]); end
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL word_k2_idle: got rdy=%0b rv=%0b required 1/0", req_ready, resp_valid); end
   endtask

   task automatic test_misaligned();
      logic en_seen = 1'b0;
      preload(10'h040, 32'h11223344);
      issue(1'b1, 1'b0, 1'b1, 32'h103, 32'h0000BEEF);
`ifdef DMEM_ALIGN_CHECK_EN
      @(negedge clk);
      en_seen |= mem_en;
      n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin n_err++; $display("FAIL misalign_err: got rv=%0b err=%0b required 1/1", resp_valid, resp_err); end
      @(negedge clk);
      en_seen |= mem_en;
      n_cmp++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL misalign_k1: got rv=%0b err=%0b rdy=%0b required 0/0/1", resp_valid, resp_err, req_ready); end
      @(negedge clk);
      en_seen |= mem_en;
      n_cmp++; if (en_seen !== 1'b0) begin n_err++; $display("FAIL misalign_no_en: got %0b required 0", en_seen); end
      n_cmp++; if (sram[10'h040] !== 32'h11223344 || resp_rdata !== 32'h11223344) begin n_err++; $display("FAIL misalign_unchanged: got mem=%h rdata=%h required 11223344/11223344", sram[10'h040], resp_rdata); end
`else
      @(negedge clk);
      en_seen |= mem_en;
      n_cmp++; if (en_seen !== 1'b1 || fsm_state !== ST_RD) begin n_err++; $display("FAIL misalign_rd: got en=%0b st=%0d required 1/%0d", en_seen, fsm_state, ST_RD); end
      repeat (3) @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin n_err++; $display("FAIL misalign_resp: got rv=%0b err=%0b required 1/0", resp_valid, resp_err); end
      n_cmp++; if (sram[10'h040] !== 32'hBEEF3344) begin n_err++; $display("FAIL misalign_as_half102: got %h required beef3344", sram[10'h040]); end
      @(negedge clk);
`endif
   endtask

   task automatic test_back_to_back();
      int k;
      preload(10'h040, 32'hA0B0C0D0);
      run_txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h00000055, k);
      n_cmp++; if (sram[10'h040] !== 32'hA0B0C055) begin n_err++; $display("FAIL b2b_byte0: got %h required a0b0c055", sram[10'h040]); end
      run_txn(1'b1, 1'b1, 1'b0, 32'h103, 32'h12345699, k);
      n_cmp++; if (sram[10'h040] !== 32'h99B0C055) begin n_err++; $display("FAIL b2b_byte3: got %h required 99b0c055", sram[10'h040]); end
      run_txn(1'b1, 1'b0, 1'b1, 32'h100, 32'h00007777, k);
      n_cmp++; if (sram[10'h040] !== 32'h99B07777) begin n_err++; $display("FAIL b2b_half0: got %h required 99b07777", sram[10'h040]); end
      run_txn(1'b1, 1'b1, 1'b1, 32'h102, 32'h0000CAFE, k);
      n_cmp++; if (sram[10'h040] !== 32'hCAFE7777) begin n_err++; $display("FAIL b2b_both_as_half: got %h required cafe7777", sram[10'h040]); end
      run_txn(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, k);
      n_cmp++; if (resp_rdata !== 32'hCAFE7777 || k != 2) begin n_err++; $display("FAIL b2b_load: got %h lat=%0d required cafe7777 lat=2", resp_rdata, k); end
      @(negedge clk);
   endtask

   task automatic test_reset_during_wr();
      preload(10'h042, 32'h11223344);
      issue(1'b1, 1'b1, 1'b0, 32'h109, 32'h000000AA);
      repeat (3) @(negedge clk);
      n_cmp++; if (fsm_state !== ST_WR || mem_we !== 1'b1) begin n_err++; $display("FAIL rstwr_in_wr: got st=%0d we=%0b required %0d/1", fsm_state, mem_we, ST_WR); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (mem_we !== 1'b0 || mem_en !== 1'b0 || fsm_state !== ST_IDLE || req_ready !== 1'b0) begin n_err++; $display("FAIL rstwr_async: got we=%0b en=%0b st=%0d rdy=%0b required 0/0/%0d/0", mem_we, mem_en, fsm_state, req_ready, ST_IDLE); end
      @(negedge clk);
      n_cmp++; if (sram[10'h042] !== 32'h11223344) begin n_err++; $display("FAIL rstwr_mem: got %h required 11223344", sram[10'h042]); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1 || sram[10'h042] !== 32'h11223344) begin n_err++; $display("FAIL rstwr_release: got rdy=%0b mem=%h required 1/11223344", req_ready, sram[10'h042]); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_byte_store();
      test_half_store();
      test_word_store();
      test_misaligned();
      test_back_to_back();
      test_reset_during_wr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
